// File: rtl/fetch_controller_pkg.sv
// rtl/fetch_controller_pkg.sv - shared types, defaults and address legality helper for the IF stage
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } fetch_state_t;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;

    // Widened to 64 bits so the IMEM_WORDS*4 limit can never overflow the compare.
    function automatic logic addr_legal(input logic [63:0] addr, input int unsigned imem_words);
        logic [63:0] lim;
        lim = 64'(imem_words) << 2;
        return (addr[1:0] == 2'b00) && (addr < lim);
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - imem, hazard/redirect and IF/ID signal bundle of the fetch stage
interface fetch_controller_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) ();

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               stall;
    logic               redirect_ex;
    logic [ADDR_W-1:0]  redirect_ex_tgt;
    logic               redirect_id;
    logic [ADDR_W-1:0]  redirect_id_tgt;
    logic               halt_req;
    logic [INSTR_W-1:0] ifid_instr;
    logic [ADDR_W-1:0]  ifid_pc;
    logic [ADDR_W-1:0]  ifid_pc_plus4;
    logic               ifid_valid;
    logic               halted;
    logic               fetch_fault;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  stall,
        input  redirect_ex,
        input  redirect_ex_tgt,
        input  redirect_id,
        input  redirect_id_tgt,
        input  halt_req,
        output ifid_instr,
        output ifid_pc,
        output ifid_pc_plus4,
        output ifid_valid,
        output halted,
        output fetch_fault
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output stall,
        output redirect_ex,
        output redirect_ex_tgt,
        output redirect_id,
        output redirect_id_tgt,
        output halt_req,
        input  ifid_instr,
        input  ifid_pc,
        input  ifid_pc_plus4,
        input  ifid_valid,
        input  halted,
        input  fetch_fault
    );

endinterface

// File: rtl/fetch_controller_ifid_reg.sv
// rtl/fetch_controller_ifid_reg.sv - IF/ID pipeline register with load/hold/kill controls
module ifid_reg #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               kill,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [ADDR_W-1:0]  pc_d,
    input  logic [ADDR_W-1:0]  pc_plus4_d,
    output logic [INSTR_W-1:0] instr_q,
    output logic [ADDR_W-1:0]  pc_q,
    output logic [ADDR_W-1:0]  pc_plus4_q,
    output logic               valid_q
);

    // Kill only clears valid; payload holds its last values for debug visibility.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (kill) begin
            valid_q    <= 1'b0;
        end else if (load) begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - IF-stage sequencer: pc register, fetch FSM, next-pc mux and legality checks
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int              ADDR_W     = ADDR_W_DEF,
    parameter int              INSTR_W    = INSTR_W_DEF,
    parameter int unsigned     IMEM_WORDS = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_controller_if.master fif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              eom_q, eom_d;
    logic              ifid_load, ifid_kill;
    logic [ADDR_W-1:0] pc_plus4;

    assign pc_plus4      = pc_q + ADDR_W'(4);
    assign fif.imem_addr = pc_q;
    assign fif.halted      = (state_q == HALTED);
    assign fif.fetch_fault = (state_q == FAULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            eom_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            eom_q   <= eom_d;
        end
    end

    // eom_q marks that the last legal word has been loaded and pc is parked on it;
    // the fault is raised on the following cycle so that word leaves IF/ID valid.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        eom_d     = eom_q;
        ifid_load = 1'b0;
        ifid_kill = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (fif.redirect_ex) begin
                    ifid_kill = 1'b1;
                    eom_d     = 1'b0;
                    if (addr_legal(64'(fif.redirect_ex_tgt), IMEM_WORDS)) pc_d = fif.redirect_ex_tgt;
                    else                                                  state_d = FAULT;
                end else if (fif.redirect_id) begin
                    ifid_kill = 1'b1;
                    eom_d     = 1'b0;
                    if (addr_legal(64'(fif.redirect_id_tgt), IMEM_WORDS)) pc_d = fif.redirect_id_tgt;
                    else                                                  state_d = FAULT;
                end else if (fif.stall) begin
                    state_d = RUN;
                end else if (eom_q) begin
                    ifid_kill = 1'b1;
                    state_d   = FAULT;
                end else if (fif.halt_req) begin
                    ifid_kill = 1'b1;
                    state_d   = HALTED;
                end else begin
                    ifid_load = 1'b1;
                    if (addr_legal(64'(pc_plus4), IMEM_WORDS)) pc_d  = pc_plus4;
                    else                                       eom_d = 1'b1;
                end
            end
            HALTED:  state_d = HALTED;
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    ifid_reg #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_ifid (
        .clk       (clk),
        .reset     (reset),
        .load      (ifid_load),
        .kill      (ifid_kill),
        .instr_d   (fif.imem_instr),
        .pc_d      (pc_q),
        .pc_plus4_d(pc_plus4),
        .instr_q   (fif.ifid_instr),
        .pc_q      (fif.ifid_pc),
        .pc_plus4_q(fif.ifid_pc_plus4),
        .valid_q   (fif.ifid_valid)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed self-checking bench for fetch_controller
module tb_fetch_controller;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    fetch_controller_if #(.ADDR_W(32), .INSTR_W(32)) fif ();

    fetch_controller #(
        .ADDR_W    (32),
        .INSTR_W   (32),
        .IMEM_WORDS(64),
        .RESET_PC  (32'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .fif  (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-word test program; word 10 (0x28) stands in for the BZ target.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a < 32'd64) begin
            case (a[5:2])
                4'd0:  w = 32'h1001_0000;
                4'd1:  w = 32'h1102_0004;
                4'd2:  w = 32'h1203_0008;
                4'd3:  w = 32'h1304_000C;
                4'd4:  w = 32'h2405_0010;
                4'd5:  w = 32'h2506_0014;
                4'd6:  w = 32'h2607_0018;
                4'd7:  w = 32'h2708_001C;
                4'd8:  w = 32'h3809_0020;
                4'd9:  w = 32'h390A_0024;
                4'd10: w = 32'h4A00_0010;
                4'd11: w = 32'h3B0C_002C;
                4'd12: w = 32'h3C0D_0030;
                4'd13: w = 32'h3D0E_0034;
                4'd14: w = 32'h5000_0000;
                default: w = 32'hFC00_0000;
            endcase
        end else begin
            w = {16'hDEAD, a[15:0]};
        end
        return w;
    endfunction

    assign fif.imem_instr = imem_word(fif.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        fif.stall = 1'b0;
        fif.redirect_ex = 1'b0;
        fif.redirect_ex_tgt = '0;
        fif.redirect_id = 1'b0;
        fif.redirect_id_tgt = '0;
        fif.halt_req = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_addr", fif.imem_addr, 32'h0);
        chk("rst_valid", 32'(fif.ifid_valid), 32'h0);
        chk("rst_pc", fif.ifid_pc, 32'h0);
        chk("rst_instr", fif.ifid_instr, 32'h0);
        chk("rst_halted", 32'(fif.halted), 32'h0);
        chk("rst_fault", 32'(fif.fetch_fault), 32'h0);
        reset = 1'b0;

        // boot cycle: no IF/ID load
        tick();
        chk("boot_valid", 32'(fif.ifid_valid), 32'h0);
        chk("boot_addr", fif.imem_addr, 32'h0);

        // sequential fetch
        tick();
        chk("seq0_pc", fif.ifid_pc, 32'h0);
        chk("seq0_valid", 32'(fif.ifid_valid), 32'h1);
        chk("seq0_instr", fif.ifid_instr, 32'h1001_0000);
        chk("seq0_pc4", fif.ifid_pc_plus4, 32'h4);
        chk("seq0_addr", fif.imem_addr, 32'h4);
        tick();
        chk("seq1_pc", fif.ifid_pc, 32'h4);
        chk("seq1_instr", fif.ifid_instr, 32'h1102_0004);
        chk("seq1_addr", fif.imem_addr, 32'h8);

        // stall two cycles at pc=0x8
        fif.stall = 1'b1;
        tick();
        chk("stall1_addr", fif.imem_addr, 32'h8);
        chk("stall1_pc", fif.ifid_pc, 32'h4);
        tick();
        chk("stall2_addr", fif.imem_addr, 32'h8);
        chk("stall2_pc", fif.ifid_pc, 32'h4);
        fif.stall = 1'b0;
        tick();
        chk("resume_pc", fif.ifid_pc, 32'h8);
        chk("resume_valid", 32'(fif.ifid_valid), 32'h1);
        chk("resume_instr", fif.ifid_instr, 32'h1203_0008);
        chk("resume_addr", fif.imem_addr, 32'hC);
        tick();
        chk("seq3_pc", fif.ifid_pc, 32'hC);
        chk("seq3_pc4", fif.ifid_pc_plus4, 32'h10);
        chk("seq3_addr", fif.imem_addr, 32'h10);

        // halt deferred by stall, then taken
        fif.halt_req = 1'b1;
        fif.stall = 1'b1;
        tick();
        chk("hdef_halted", 32'(fif.halted), 32'h0);
        chk("hdef_addr", fif.imem_addr, 32'h10);
        chk("hdef_valid", 32'(fif.ifid_valid), 32'h1);
        fif.stall = 1'b0;
        tick();
        chk("halt_halted", 32'(fif.halted), 32'h1);
        chk("halt_valid", 32'(fif.ifid_valid), 32'h0);
        chk("halt_addr", fif.imem_addr, 32'h10);
        chk("halt_pc", fif.ifid_pc, 32'hC);
        fif.redirect_ex = 1'b1;
        fif.redirect_ex_tgt = 32'h20;
        tick();
        chk("halt_ign_addr", fif.imem_addr, 32'h10);
        chk("halt_stays", 32'(fif.halted), 32'h1);
        fif.redirect_ex = 1'b0;
        fif.halt_req = 1'b0;

        // async reset mid-cycle at pc=0x1C
        do_reset();
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("pre_arst_addr", fif.imem_addr, 32'h1C);
        chk("pre_arst_pc", fif.ifid_pc, 32'h18);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_addr", fif.imem_addr, 32'h0);
        chk("arst_valid", 32'(fif.ifid_valid), 32'h0);
        chk("arst_halted", 32'(fif.halted), 32'h0);
        chk("arst_fault", 32'(fif.fetch_fault), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("reboot_valid", 32'(fif.ifid_valid), 32'h0);
        chk("reboot_addr", fif.imem_addr, 32'h0);
        tick();
        chk("restart_pc", fif.ifid_pc, 32'h0);
        chk("restart_addr", fif.imem_addr, 32'h4);

        // redirect_ex beats redirect_id and stall
        fif.redirect_ex = 1'b1;
        fif.redirect_ex_tgt = 32'h28;
        fif.redirect_id = 1'b1;
        fif.redirect_id_tgt = 32'h38;
        fif.stall = 1'b1;
        tick();
        chk("rdx_addr", fif.imem_addr, 32'h28);
        chk("rdx_bubble", 32'(fif.ifid_valid), 32'h0);
        fif.redirect_ex = 1'b0;
        fif.redirect_id = 1'b0;
        fif.stall = 1'b0;
        tick();
        chk("rdx_pc", fif.ifid_pc, 32'h28);
        chk("rdx_valid", 32'(fif.ifid_valid), 32'h1);
        chk("rdx_instr", fif.ifid_instr, 32'h4A00_0010);
        chk("rdx_next", fif.imem_addr, 32'h2C);

        // misaligned redirect_id target faults
        fif.redirect_id = 1'b1;
        fif.redirect_id_tgt = 32'h2A;
        tick();
        chk("mis_fault", 32'(fif.fetch_fault), 32'h1);
        chk("mis_valid", 32'(fif.ifid_valid), 32'h0);
        chk("mis_addr", fif.imem_addr, 32'h2C);
        chk("mis_pc", fif.ifid_pc, 32'h28);
        fif.redirect_id = 1'b0;
        fif.redirect_ex = 1'b1;
        fif.redirect_ex_tgt = 32'h30;
        tick();
        chk("fault_ign_addr", fif.imem_addr, 32'h2C);
        chk("fault_sticky", 32'(fif.fetch_fault), 32'h1);
        fif.redirect_ex = 1'b0;

        // end of memory: redirect during BOOT ignored, then run off the end from 0xF8
        reset = 1'b1;
        fif.redirect_ex = 1'b1;
        fif.redirect_ex_tgt = 32'hF8;
        tick();
        reset = 1'b0;
        tick();
        chk("boot_ign_addr", fif.imem_addr, 32'h0);
        tick();
        chk("eom_rd_addr", fif.imem_addr, 32'hF8);
        chk("eom_rd_valid", 32'(fif.ifid_valid), 32'h0);
        fif.redirect_ex = 1'b0;
        tick();
        chk("eom_f8_pc", fif.ifid_pc, 32'hF8);
        chk("eom_f8_addr", fif.imem_addr, 32'hFC);
        tick();
        chk("eom_fc_pc", fif.ifid_pc, 32'hFC);
        chk("eom_fc_valid", 32'(fif.ifid_valid), 32'h1);
        chk("eom_fc_instr", fif.ifid_instr, 32'hDEAD_00FC);
        chk("eom_fc_pc4", fif.ifid_pc_plus4, 32'h100);
        chk("eom_fc_addr", fif.imem_addr, 32'hFC);
        tick();
        chk("eom_fault", 32'(fif.fetch_fault), 32'h1);
        chk("eom_valid", 32'(fif.ifid_valid), 32'h0);
        chk("eom_addr", fif.imem_addr, 32'hFC);
        chk("eom_pc_hold", fif.ifid_pc, 32'hFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
